// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: bundle between the execute-stage FUs, the CDB arbiter and
// the CDB consumers.
//   fu_out_packet[NUM_FU] : registered FU results (done, v, rob_tag,
//                           take_branch, branch_loc)
//   squash                : branch-mispredict flush
//   ack[NUM_FU]           : combinational grant back to each FU
//   cdb_*                 : registered broadcast (valid, tag, value,
//                           take_branch, branch_loc)
// master = arbiter side, slave = FU/consumer side.
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int ROB_TAG_W = 5
);
    typedef struct packed {
        logic                 done;
        logic [`XLEN-1:0]     v;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic                 take_branch;
        logic [`XLEN-1:0]     branch_loc;
    } FU_OUT_PACKET;

    FU_OUT_PACKET         fu_out_packet [NUM_FU];
    logic                 squash;
    logic [NUM_FU-1:0]    ack;
    logic                 cdb_valid;
    logic [ROB_TAG_W-1:0] cdb_tag;
    logic [`XLEN-1:0]     cdb_value;
    logic                 cdb_take_branch;
    logic [`XLEN-1:0]     cdb_branch_loc;

    modport master (
        input  fu_out_packet, squash,
        output ack, cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_branch_loc
    );

    modport slave (
        output fu_out_packet, squash,
        input  ack, cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_branch_loc
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter + broadcast register for the Common Data Bus.
// Picks at most one done FU per cycle (search starts at ptr), acks it in the
// same cycle and registers its result onto the CDB for the next cycle.
// Squash acks every done FU at once and suppresses the broadcast.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears ptr, ack and cdb_*
//   cdb   : cdb_arbiter_if.master (fu_out_packet/squash in, ack/cdb_* out)
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int ROB_TAG_W = 5
) (
    input  logic           clock,
    input  logic           reset,
    cdb_arbiter_if.master  cdb
);
    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]    req;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     win_idx;
    logic                 found;
    logic [NUM_FU-1:0]    gnt_oh;
    logic                 grant;

    logic                 cdb_valid_q, cdb_valid_d;
    logic [ROB_TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [`XLEN-1:0]     cdb_value_q, cdb_value_d;
    logic                 cdb_tb_q, cdb_tb_d;
    logic [`XLEN-1:0]     cdb_bl_q, cdb_bl_d;

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) req[i] = cdb.fu_out_packet[i].done;
    end

    // Rotating search from ptr_q. The index is wrapped with an explicit
    // subtract so non-power-of-two NUM_FU never walks past the last FU.
    always_comb begin
        logic [PTR_W:0] sum;
        logic [PTR_W-1:0] idx;
        found   = 1'b0;
        win_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
    end

    assign gnt_oh = found ? (NUM_FU'(1) << win_idx) : '0;
    assign grant  = found && !cdb.squash;

    // Squash drains every done FU in one cycle; reset forces ack low
    // without waiting for an edge.
    assign cdb.ack = reset      ? '0  :
                     cdb.squash ? req : gnt_oh;

    always_comb begin
        ptr_d       = ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        cdb_tb_d    = 1'b0;
        cdb_bl_d    = '0;
        if (grant) begin
            ptr_d       = (win_idx == PTR_W'(NUM_FU-1)) ? '0 : win_idx + PTR_W'(1);
            cdb_valid_d = 1'b1;
            cdb_tag_d   = cdb.fu_out_packet[win_idx].rob_tag;
            cdb_value_d = cdb.fu_out_packet[win_idx].v;
            cdb_tb_d    = cdb.fu_out_packet[win_idx].take_branch;
            cdb_bl_d    = cdb.fu_out_packet[win_idx].branch_loc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_tb_q    <= 1'b0;
            cdb_bl_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_tb_q    <= cdb_tb_d;
            cdb_bl_q    <= cdb_bl_d;
        end
    end

    assign cdb.cdb_valid       = cdb_valid_q;
    assign cdb.cdb_tag         = cdb_tag_q;
    assign cdb.cdb_value       = cdb_value_q;
    assign cdb.cdb_take_branch = cdb_tb_q;
    assign cdb.cdb_branch_loc  = cdb_bl_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus randomized traffic for cdb_arbiter,
// checked against a behavioural round-robin model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 5;
    localparam int XL = `XLEN;

    typedef struct {
        logic          done;
        logic [XL-1:0] v;
        logic [TW-1:0] tag;
        logic          tb;
        logic [XL-1:0] bl;
    } pkt_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cdb_arbiter_if #(.NUM_FU(N), .ROB_TAG_W(TW)) bus();

    cdb_arbiter #(.NUM_FU(N), .ROB_TAG_W(TW)) dut (
        .clock (clock),
        .reset (reset),
        .cdb   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    pkt_t          fu [N];
    int            mp;
    logic          e_valid;
    logic [TW-1:0] e_tag;
    logic [XL-1:0] e_v;
    logic          e_tb;
    logic [XL-1:0] e_bl;
    logic [N-1:0]  last_ack;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.done = 1'b1;
        p.v    = $urandom;
        p.tag  = TW'($urandom);
        p.tb   = 1'($urandom_range(0, 1));
        p.bl   = $urandom;
        return p;
    endfunction

    function automatic pkt_t mk(input logic [XL-1:0] v, input int tag,
                                input logic tb, input logic [XL-1:0] bl);
        pkt_t p;
        p.done = 1'b1; p.v = v; p.tag = TW'(tag); p.tb = tb; p.bl = bl;
        return p;
    endfunction

    task automatic clear_fus();
        for (int i = 0; i < N; i++) begin
            fu[i].done = 1'b0; fu[i].v = '0; fu[i].tag = '0; fu[i].tb = 1'b0; fu[i].bl = '0;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.fu_out_packet[i].done        = fu[i].done;
            bus.fu_out_packet[i].v           = fu[i].v;
            bus.fu_out_packet[i].rob_tag     = fu[i].tag;
            bus.fu_out_packet[i].take_branch = fu[i].tb;
            bus.fu_out_packet[i].branch_loc  = fu[i].bl;
        end
    endtask

    task automatic model_clear();
        mp = 0; e_valid = 1'b0; e_tag = '0; e_v = '0; e_tb = 1'b0; e_bl = '0;
    endtask

    // Expected grant: squash acks every requester, otherwise the first
    // requester met walking forward (mod N) from the model pointer.
    function automatic logic [N-1:0] model_ack(input logic sq, output int win);
        logic [N-1:0] r;
        win = -1;
        for (int i = 0; i < N; i++) r[i] = fu[i].done;
        if (sq) return r;
        for (int k = 0; k < N; k++)
            if (win < 0 && r[(mp + k) % N]) win = (mp + k) % N;
        return (win < 0) ? '0 : (N'(1) << win);
    endfunction

    task automatic check_cdb();
        chk("cdb_valid", bus.cdb_valid, e_valid);
        chk("cdb_tag", bus.cdb_tag, e_tag);
        chk("cdb_value", bus.cdb_value, e_v);
        chk("cdb_take_branch", bus.cdb_take_branch, e_tb);
        chk("cdb_branch_loc", bus.cdb_branch_loc, e_bl);
    endtask

    // One cycle, entered and left at a negedge.
    task automatic step(input logic sq);
        logic [N-1:0] ea;
        int win;
        bus.squash = sq;
        drive();
        #1;
        ea = model_ack(sq, win);
        last_ack = bus.ack;
        chk("ack", bus.ack, ea);
        @(posedge clock);
        if (!sq && win >= 0) begin
            mp = (win + 1) % N;
            e_valid = 1'b1; e_tag = fu[win].tag; e_v = fu[win].v;
            e_tb = fu[win].tb; e_bl = fu[win].bl;
        end else begin
            e_valid = 1'b0; e_tag = '0; e_v = '0; e_tb = 1'b0; e_bl = '0;
        end
        for (int i = 0; i < N; i++) if (ea[i]) fu[i].done = 1'b0;
        #1;
        check_cdb();
        @(negedge clock);
        bus.squash = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_fus();
        model_clear();
        drive();
        #1;
        chk("rst_ack", bus.ack, '0);
        chk("rst_valid", bus.cdb_valid, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int cnt [N];
        bus.squash = 1'b0;
        clear_fus();
        model_clear();
        drive();
        #2;
        chk("init_ack", bus.ack, '0);
        check_cdb();
        @(negedge clock);
        reset = 1'b0;

        // async reset mid-cycle with FU1 done
        fu[1] = mk(32'h11, 3, 1'b0, '0);
        step(1'b0);
        fu[1] = mk(32'h22, 4, 1'b0, '0);
        drive();
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ack", bus.ack, '0);
        chk("async_rst_valid", bus.cdb_valid, 1'b0);
        chk("async_rst_tag", bus.cdb_tag, '0);
        clear_fus();
        model_clear();
        drive();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        fu[1] = mk(32'h33, 5, 1'b0, '0);
        fu[2] = mk(32'h44, 6, 1'b0, '0);
        step(1'b0);
        chk("rst_first_grant", last_ack, 4'b0010);
        step(1'b0);
        step(1'b0);

        // single request
        fu[2] = mk(32'h0000_00AA, 7, 1'b0, '0);
        step(1'b0);
        chk("single_ack", last_ack, 4'b0100);
        chk("single_valid", bus.cdb_valid, 1'b1);
        chk("single_tag", bus.cdb_tag, 7);
        chk("single_value", bus.cdb_value, 32'hAA);
        step(1'b0);
        chk("single_idle", bus.cdb_valid, 1'b0);

        // round-robin fairness, all FUs kept done
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) if (!fu[i].done) fu[i] = rand_pkt();
            step(1'b0);
            chk("rr_seq", last_ack, N'(1) << (c % N));
            for (int i = 0; i < N; i++) if (last_ack[i]) cnt[i]++;
        end
        for (int i = 0; i < N; i++) chk("rr_count", cnt[i], 2);

        // wrap-around from ptr = 3
        do_reset();
        fu[2] = rand_pkt();
        step(1'b0);
        fu[0] = rand_pkt();
        fu[3] = rand_pkt();
        step(1'b0);
        chk("wrap_first", last_ack, 4'b1000);
        step(1'b0);
        chk("wrap_second", last_ack, 4'b0001);

        // squash drain, pointer holds at 1
        do_reset();
        fu[0] = rand_pkt();
        step(1'b0);
        fu[0] = rand_pkt(); fu[1] = rand_pkt(); fu[3] = rand_pkt();
        step(1'b1);
        chk("squash_ack", last_ack, 4'b1011);
        chk("squash_valid", bus.cdb_valid, 1'b0);
        for (int i = 0; i < N; i++) fu[i] = rand_pkt();
        step(1'b0);
        chk("squash_ptr_hold", last_ack, 4'b0010);
        for (int c = 0; c < N; c++) step(1'b0);

        // branch passthrough
        fu[1] = mk(32'h0000_1004, 9, 1'b1, 32'h0000_2000);
        step(1'b0);
        chk("br_take", bus.cdb_take_branch, 1'b1);
        chk("br_value", bus.cdb_value, 32'h1004);
        chk("br_loc", bus.cdb_branch_loc, 32'h2000);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!fu[i].done && $urandom_range(0, 2) == 0) fu[i] = rand_pkt();
            if ($urandom_range(0, 99) == 0) do_reset();
            else step($urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter and broadcast register for the Common Data Bus. It sits directly downstream of the execute-stage functional units (`alu_fu` and siblings). Each cycle it selects at most one FU whose registered `FU_OUT_PACKET` has `done` set, returns that FU's `ack`, and drives the selected result onto registered CDB outputs. Those outputs feed the ROB, the reservation stations and the map table.

## Interface

Parameters:
- `NUM_FU`, default 4: number of FU result ports; must be ≥ 2.
- `ROB_TAG_W`, default 5: width of `rob_tag`; must equal the `rob_tag` field width in `FU_OUT_PACKET`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: asynchronous, active-high; clears all state and outputs immediately.
- `squash`, input, 1: branch-mispredict flush, sampled at the clock edge.
- `fu_out_packet[NUM_FU]`, input, `FU_OUT_PACKET` each: registered FU results. Fields used: `done`, `v`, `rob_tag`, `take_branch`, `branch_loc`.
- `ack`, output, `NUM_FU`: combinational grant, one-hot or zero; drives each FU's `ack` input.
- `cdb_valid`, output, 1: broadcast valid.
- `cdb_tag`, output, `ROB_TAG_W`: ROB tag being completed.
- `cdb_value`, output, `` `XLEN ``: result value (NPC for taken branches, as produced by the FU).
- `cdb_take_branch`, output, 1: branch resolved taken.
- `cdb_branch_loc`, output, `` `XLEN ``: branch target.

## Operation

- Request vector: `req[i] = fu_out_packet[i].done`.
- Priority pointer:
  - `ptr` is a `$clog2(NUM_FU)`-bit register; reset value 0.
  - Search order is `ptr`, `ptr+1`, …, `NUM_FU-1`, `0`, …, `ptr-1`. The first requester in that order wins.
- Grant (combinational, same cycle as `req`):
  - Normal: `ack` = one-hot of the winner; `ack = 0` when `req = 0`.
  - Squash: when `squash = 1`, `ack = req`. Every done FU is acked so stale results drain in one cycle, and no winner is selected.
- Pointer update at the clock edge:
  - On a normal grant to FU i: `ptr <= (i+1) mod NUM_FU`. Wrap from `NUM_FU-1` goes to 0. For non-power-of-two `NUM_FU`, wrap explicitly and never rely on natural overflow.
  - When no grant, or during squash: `ptr` holds.
- Broadcast register at the clock edge:
  - Normal grant to FU i: `cdb_valid <= 1`. `cdb_tag`, `cdb_value`, `cdb_take_branch` and `cdb_branch_loc` capture FU i's fields.
  - No grant or squash: `cdb_valid <= 0`. The data fields are zeroed so idle bus values are deterministic.
- Reset:
  - All outputs are 0 while `reset` is high: `ack = 0`, `cdb_*` = 0, `ptr` = 0.
  - Assertion mid-operation clears the outputs asynchronously, without waiting for an edge.
  - The first grant after deassertion uses `ptr = 0`.
- FU contract (verified, not enforced):
  - An FU holds `done` until acked.
  - An acked FU has `done = 0` from the next edge.
  - The arbiter never acks an FU whose `done` is 0.

## Timing

- Latency: `done` visible in cycle t → `ack` in cycle t → `cdb_valid` plus data in cycle t+1. The FU's packet is cleared at the same edge.
- Throughput: one broadcast per cycle. With k FUs continuously done, each wins once every k cycles; there is no starvation.
- `ack` depends only on registered inputs (`fu_out_packet`, `squash`, `ptr`). There is no combinational loop through the FU.
- Simultaneous events:
  - `reset` dominates `squash`.
  - `squash` dominates a normal grant.
  - A squash in cycle t produces `cdb_valid = 0` in t+1. A broadcast already registered in cycle t stays visible during t; consumers qualify it with `squash` themselves.
- A request arriving in the cycle after its FU was acked is treated as a new result and is granted normally.

## Test plan

- **Reset:** assert `reset` asynchronously mid-cycle with FU1 done.
  - `ack` and `cdb_valid` drop to 0 before the next edge.
  - After release, with FU1 and FU2 done, the first grant goes to FU1.
- **Single request:** FU2 done with `v = 0x0000_00AA`, tag 7.
  - Same cycle: `ack = 4'b0100`.
  - Next cycle: `cdb_valid = 1`, `cdb_tag = 7`, `cdb_value = 0xAA`.
  - Cycle after: `cdb_valid = 0`.
- **Round-robin fairness:** all 4 FUs held done, each refilled immediately after its ack.
  - Grant sequence is 0, 1, 2, 3, 0, 1, …
  - Each FU is granted exactly 2 times in 8 cycles.
- **Wrap-around:** with `ptr = 3`, FU0 and FU3 done.
  - Grant goes to FU3, then `ptr = 0`.
  - Next cycle FU0 is granted.
- **Squash drain:** FU0, FU1 and FU3 done; `squash = 1` for one cycle.
  - `ack = 4'b1011`.
  - Next cycle `cdb_valid = 0`.
  - `ptr` is unchanged from its prior value.
- **Branch passthrough:** FU1 done with `take_branch = 1`, `v = 0x0000_1004`, `branch_loc = 0x0000_2000`.
  - Next cycle: `cdb_take_branch = 1`, `cdb_value = 0x1004`, `cdb_branch_loc = 0x2000`.
